// File: rtl/sm83_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : sm83_bus_responder
//  Description : SM83 memory-side responder. It decodes the high page (HRAM,
//                IE/IF, boot latch), runs OAM DMA and locks the core out of
//                the external bus while DMA is active.
//  Revision    : 1.0 - initial release
// ============================================================================
module sm83_bus_responder #(
    parameter int DMA_LEN    = 160,
    parameter int HRAM_DEPTH = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] r_addr,
    output logic [7:0]  r_data,
    input  logic [15:0] w_addr,
    input  logic [7:0]  w_data,
    input  logic        w_wen,
    output logic [15:0] ext_raddr,
    input  logic [7:0]  ext_rdata,
    output logic [15:0] ext_waddr,
    output logic [7:0]  ext_wdata,
    output logic        ext_wen,
    input  logic [7:0]  boot_rdata,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_wen,
    input  logic [4:0]  irq_req,
    output logic [4:0]  irq_pending,
    output logic        dma_active
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_START     = 2'd1;
    localparam logic [1:0] c_XFER      = 2'd2;
    localparam logic [7:0] c_IDX_LAST  = 8'(DMA_LEN - 1);
    localparam logic [6:0] c_HRAM_LAST = 7'(HRAM_DEPTH - 1);

    logic [7:0] r_ie;
    logic [4:0] r_if;
    logic       r_boot_en;
    logic [7:0] r_dma_src;
    logic [7:0] r_idx;
    logic [1:0] r_state;
    logic [7:0] r_hram [0:HRAM_DEPTH-1];

    logic       w_rd_high;
    logic       w_rd_hram;
    logic       w_wr_high;
    logic       w_wr_hram;
    logic       w_wr_internal;
    logic [7:0] w_src_eff;

    assign w_rd_high = (r_addr[15:8] == 8'hFF);
    assign w_rd_hram = (r_addr[15:7] == 9'h1FF) && (r_addr[6:0] <= c_HRAM_LAST);
    assign w_wr_high = (w_addr[15:8] == 8'hFF);
    assign w_wr_hram = (w_addr[15:7] == 9'h1FF) && (w_addr[6:0] <= c_HRAM_LAST);
    assign w_wr_internal = (w_addr == 16'hFF0F) || (w_addr == 16'hFF46) ||
                           (w_addr == 16'hFF50) || (w_addr == 16'hFFFF) || w_wr_hram;

    // Sources in the E0-FF echo region alias down onto work RAM.
    assign w_src_eff = (r_dma_src >= 8'hE0) ? (r_dma_src - 8'h20) : r_dma_src;

    assign dma_active  = (r_state != c_IDLE);
    assign irq_pending = r_ie[4:0] & r_if;

    assign ext_raddr = (r_state == c_XFER) ? {w_src_eff, r_idx} : r_addr;
    assign ext_waddr = w_addr;
    assign ext_wdata = w_data;
    assign ext_wen   = w_wen && !w_wr_internal && !(dma_active && !w_wr_high);

    assign oam_addr  = r_idx;
    assign oam_wdata = ext_rdata;
    assign oam_wen   = (r_state == c_XFER);

    always_comb begin
        r_data = ext_rdata;
        if (dma_active && !w_rd_high) begin
            r_data = 8'hFF;
        end else if ((r_addr[15:8] == 8'h00) && r_boot_en) begin
            r_data = boot_rdata;
        end else if (r_addr == 16'hFF0F) begin
            r_data = {3'b111, r_if};
        end else if (r_addr == 16'hFF46) begin
            r_data = r_dma_src;
        end else if (r_addr == 16'hFF50) begin
            r_data = 8'hFF;
        end else if (w_rd_hram) begin
            r_data = r_hram[r_addr[6:0]];
        end else if (r_addr == 16'hFFFF) begin
            r_data = r_ie;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ie      <= 8'h00;
            r_if      <= 5'h00;
            r_boot_en <= 1'b1;
            r_dma_src <= 8'h00;
            r_idx     <= 8'h00;
            r_state   <= c_IDLE;
        end else begin
            // A request in the same cycle as a clearing write still lands.
            r_if <= ((w_wen && (w_addr == 16'hFF0F)) ? w_data[4:0] : r_if) | irq_req;

            if (w_wen && (w_addr == 16'hFFFF)) begin
                r_ie <= w_data;
            end
            if (w_wen && (w_addr == 16'hFF50) && (w_data != 8'h00)) begin
                r_boot_en <= 1'b0;
            end

            if (w_wen && (w_addr == 16'hFF46)) begin
                r_dma_src <= w_data;
                r_idx     <= 8'h00;
                r_state   <= c_START;
            end else begin
                case (r_state)
                    c_START: r_state <= c_XFER;
                    c_XFER: begin
                        if (r_idx == c_IDX_LAST) begin
                            r_idx   <= 8'h00;
                            r_state <= c_IDLE;
                        end else begin
                            r_idx <= r_idx + 8'h01;
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wen && w_wr_hram) begin
            r_hram[w_addr[6:0]] <= w_data;
        end
    end

endmodule
`default_nettype wire
